// File: rtl/cape_dec_pkg.sv
// Shared types and helpers for the CAPE stochastic-stream decoder.
package cape_dec_pkg;

  localparam int unsigned DEF_CNT_W = 16;
  localparam int unsigned DEF_OUT_W = 8;
  localparam int unsigned LEN_W     = $clog2(DEF_CNT_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } dec_state_e;

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned cnt_w);
    return (len > cnt_w) ? cnt_w : len;
  endfunction

  // ones * 2^out_w / 2^len_q, truncated; caller saturates to out_w bits.
  function automatic logic [63:0] norm_raw(input logic [63:0] ones,
                                           input int unsigned len_q,
                                           input int unsigned out_w);
    return (ones << out_w) >> len_q;
  endfunction

endpackage

// File: rtl/sc_norm_shift.sv
// Combinational normaliser: scales a ones count over a 2^len_q stream to an OUT_W-bit fraction.
module sc_norm_shift
  import cape_dec_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned OUT_W = DEF_OUT_W,
  parameter int unsigned LW    = $clog2(CNT_W + 1)
) (
  input  logic [CNT_W:0]   ones,
  input  logic [LW-1:0]    len_q,
  output logic [OUT_W-1:0] out_value
);

  logic [63:0] raw;

  assign raw       = norm_raw(64'(ones), 32'(len_q), OUT_W);
  // An all-ones stream yields exactly 2^OUT_W, which must clip to full scale.
  assign out_value = (|(raw >> OUT_W)) ? {OUT_W{1'b1}} : raw[OUT_W-1:0];

endmodule

// File: rtl/cape_stream_decoder.sv
// Counts ones in a 2^len_log2-bit stochastic stream and emits the normalised binary value.
module cape_stream_decoder
  import cape_dec_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned OUT_W = DEF_OUT_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic                           in_bit,
  input  logic                           in_last,
  output logic                           in_ready,
  input  logic [$clog2(CNT_W+1)-1:0]     len_log2,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_W-1:0]               out_value,
  output logic                           out_err,
  output logic                           busy
);

  localparam int unsigned LW = $clog2(CNT_W + 1);

  dec_state_e       state_reg;
  logic [CNT_W:0]   ones_reg;
  logic [CNT_W:0]   nbits_reg;
  logic [LW-1:0]    len_q_reg;
  logic [OUT_W-1:0] value_reg;
  logic             err_reg;

  logic             in_idle;
  logic             accept;
  logic [LW-1:0]    len_in;
  logic [LW-1:0]    len_eff;
  logic [CNT_W:0]   ones_next;
  logic [CNT_W:0]   k_next;
  logic             full;
  logic             term;
  logic             term_err;
  logic [OUT_W-1:0] norm_value;

  assign in_idle   = (state_reg == IDLE);
  assign in_ready  = (state_reg != HOLD);
  assign out_valid = (state_reg == HOLD);
  assign busy      = !in_idle;
  assign out_value = value_reg;
  assign out_err   = err_reg;

  // flush suppresses the accept so a bit presented alongside it is dropped.
  assign accept    = in_valid & in_ready & ~flush;

  assign len_in    = LW'(clamp_len(32'(len_log2), CNT_W));
  assign len_eff   = in_idle ? len_in : len_q_reg;
  assign ones_next = (in_idle ? '0 : ones_reg) + (CNT_W+1)'(in_bit);
  assign k_next    = (in_idle ? '0 : nbits_reg) + (CNT_W+1)'(1);
  assign full      = (k_next == ((CNT_W+1)'(1) << len_eff));
  assign term      = in_last | full;
  // Exactly one of the two end conditions firing means the producer disagreed on length.
  assign term_err  = in_last ^ full;

  sc_norm_shift #(
    .CNT_W (CNT_W),
    .OUT_W (OUT_W),
    .LW    (LW)
  ) u_norm (
    .ones      (ones_next),
    .len_q     (len_eff),
    .out_value (norm_value)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ones_reg  <= '0;
      nbits_reg <= '0;
      len_q_reg <= '0;
      value_reg <= '0;
      err_reg   <= 1'b0;
    end else if (flush) begin
      state_reg <= IDLE;
      ones_reg  <= '0;
      nbits_reg <= '0;
      len_q_reg <= '0;
      value_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, ACCUM: begin
          if (accept) begin
            ones_reg  <= ones_next;
            nbits_reg <= k_next;
            if (in_idle) begin
              len_q_reg <= len_in;
            end
            if (term) begin
              state_reg <= HOLD;
              value_reg <= norm_value;
              err_reg   <= term_err;
            end else begin
              state_reg <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_reg <= IDLE;
            ones_reg  <= '0;
            nbits_reg <= '0;
            len_q_reg <= '0;
            value_reg <= '0;
            err_reg   <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cape_stream_decoder.sv
// Self-checking bench for cape_stream_decoder: directed vectors, control corners, random streams.
module tb_cape_stream_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_bit;
  logic       in_last;
  logic       in_ready;
  logic [4:0] len_log2;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_value;
  logic       out_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  cape_stream_decoder #(.CNT_W(16), .OUT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .len_log2  (len_log2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: stream ends at the first of in_last or bit number 2^len; value = ones*256/2^len.
  function automatic void model(input int len, input bit q[$], input int last_pos,
                                output int nsent, output int val, output bit err);
    int     lq;
    longint l;
    longint v;
    int     ones;
    lq    = (len > 16) ? 16 : len;
    l     = longint'(1) << lq;
    ones  = 0;
    nsent = 0;
    for (int i = 0; i < q.size(); i++) begin
      ones += int'(q[i]);
      nsent = i + 1;
      if (nsent == last_pos || longint'(nsent) == l) break;
    end
    err = (nsent == last_pos) != (longint'(nsent) == l);
    v   = (longint'(ones) * 256) / l;
    val = (v > 255) ? 255 : int'(v);
  endfunction

  // Entered and left at posedge+1.
  task automatic drive(input int len, input bit q[$], input int nsent, input int last_pos, input bit gaps);
    for (int i = 0; i < nsent; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_bit   = q[i];
      in_last  = (i + 1 == last_pos);
      len_log2 = (i == 0) ? 5'(len) : 5'($urandom_range(0, 31));
      @(negedge clk);
      chk("in_ready_stream", in_ready, 1);
      chk("out_valid_early", out_valid, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic finish_result(input string name, input int exp_val, input bit exp_err, input int hold);
    @(negedge clk);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_value"}, out_value, exp_val);
    chk({name, "_err"}, out_err, exp_err);
    chk({name, "_in_ready"}, in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_bit   = 1'b1;
      @(negedge clk);
      chk({name, "_hold_valid"}, out_valid, 1);
      chk({name, "_hold_value"}, out_value, exp_val);
      chk({name, "_hold_in_ready"}, in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_bit    = 1'b1;
    in_last   = 1'b1;
    len_log2  = 5'd0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    @(negedge clk);
    chk({name, "_done_valid"}, out_valid, 0);
    chk({name, "_done_busy"}, busy, 0);
    chk({name, "_done_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    $display("stream %s: value=%0d err=%0d hold=%0d", name, exp_val, exp_err, hold);
  endtask

  typedef struct {
    string       name;
    int          len;
    int          n;
    logic [31:0] bits;
    int          last_pos;
    int          exp_val;
    bit          exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit q[$];
    int nsent;
    int mval;
    bit merr;
    logic [31:0] t1_bits;

    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
    len_log2 = '0; flush = 1'b0; out_ready = 1'b0;
    t1_bits = 32'h0000_B6C9;

    vecs[0] = '{"len4_9ones",    4, 16, 32'h0000_B6C9, 16,  144, 1'b0};
    vecs[1] = '{"len3_sat",      3,  8, 32'h0000_00FF,  8,  255, 1'b0};
    vecs[2] = '{"len3_short",    3,  5, 32'h0000_001A,  5,   96, 1'b1};
    vecs[3] = '{"len0_one",      0,  1, 32'h0000_0001,  1,  255, 1'b0};
    vecs[4] = '{"len0_zero_nol", 0,  1, 32'h0000_0000,  0,    0, 1'b1};
    vecs[5] = '{"len5_16ones",   5, 32, 32'hFFFF_0000, 32,  128, 1'b0};
    vecs[6] = '{"len20_clamp",  20,  4, 32'h0000_000F,  4,    0, 1'b1};
    vecs[7] = '{"len9_short",    9,  3, 32'h0000_0007,  3,    1, 1'b1};

    @(posedge clk); #2;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_value", out_value, 0);
    chk("reset_out_err", out_err, 0);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[vi]) begin
      q.delete();
      for (int b = vecs[vi].n - 1; b >= 0; b--) q.push_back(vecs[vi].bits[b]);
      model(vecs[vi].len, q, vecs[vi].last_pos, nsent, mval, merr);
      drive(vecs[vi].len, q, nsent, vecs[vi].last_pos, 1'b0);
      finish_result(vecs[vi].name, vecs[vi].exp_val, vecs[vi].exp_err, 0);
    end

    // Backpressure on the first vector.
    q.delete();
    for (int b = 15; b >= 0; b--) q.push_back(t1_bits[b]);
    drive(4, q, 16, 16, 1'b0);
    finish_result("backpressure", 144, 1'b0, 3);

    // Full-length 4096-bit stream without in_last.
    q.delete();
    for (int b = 0; b < 4096; b++) q.push_back(bit'(b & 1));
    drive(12, q, 4096, 0, 1'b0);
    finish_result("len12_nolast", 128, 1'b1, 0);

    // Flush mid-stream drops the stream and the bit presented with it.
    q.delete();
    for (int b = 0; b < 7; b++) q.push_back(1'b1);
    drive(4, q, 7, 0, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    @(posedge clk); #1;
    $display("flush mid-stream applied");
    q.delete();
    q.push_back(1'b1);
    drive(0, q, 1, 0, 1'b0);
    finish_result("after_flush", 255, 1'b1, 0);

    // Flush during HOLD with out_ready high discards the result.
    q.delete();
    for (int b = 15; b >= 0; b--) q.push_back(t1_bits[b]);
    drive(4, q, 16, 16, 1'b0);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("flush_hold_valid", out_valid, 0);
    chk("flush_hold_busy", busy, 0);
    chk("flush_hold_value", out_value, 0);
    @(posedge clk); #1;
    $display("flush in hold applied");

    // Asynchronous reset mid-ACCUM and mid-HOLD.
    q.delete();
    for (int b = 15; b >= 0; b--) q.push_back(t1_bits[b]);
    drive(4, q, 5, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_accum_busy", busy, 0);
    chk("rst_accum_valid", out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(4, q, 16, 16, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_hold_valid", out_valid, 0);
    chk("rst_hold_value", out_value, 0);
    chk("rst_hold_err", out_err, 0);
    chk("rst_hold_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("async reset sequences applied");

    // Random streams against the reference model.
    for (int r = 0; r < 40; r++) begin
      int len;
      int lq;
      int l;
      int last_pos;
      int p;
      int qn;
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(17, 20) : $urandom_range(0, 9);
      lq  = (len > 16) ? 16 : len;
      l   = 1 << lq;
      if (len > 16) last_pos = $urandom_range(1, 20);
      else last_pos = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, l + 1);
      qn = (len > 16) ? last_pos : l;
      p  = $urandom_range(0, 4);
      q.delete();
      for (int b = 0; b < qn; b++) q.push_back($urandom_range(0, 3) < p);
      model(len, q, last_pos, nsent, mval, merr);
      drive(len, q, nsent, last_pos, 1'b1);
      finish_result($sformatf("rand%0d_len%0d", r, len), mval, merr, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cape_stream_decoder.md
Name: cape_stream_decoder

Overview:
Stochastic-to-binary converter at the consumer end of the CAPE bitstream path. Accepts one SC bit per cycle over a valid/ready handshake and counts ones. Stream length is 2^len_log2, matching the early-terminated generator setting. At stream end, normalises the ones count to an OUT_W-bit binary value and presents it on a valid/ready output handshake.

Parameters:
CNT_W, 16, log2 of maximum stream length; len_log2 range 0..CNT_W
OUT_W, 8, width of normalised binary result

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
in_valid  in  1  stream bit present
in_bit  in  1  SC stream bit
in_last  in  1  producer marks final bit, e.g. from generator done
in_ready  out  1  decoder can accept a bit
len_log2  in  $clog2(CNT_W+1)  log2 of expected stream length; sampled on first accepted bit
flush  in  1  synchronous abort; discards stream or pending result
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_value  out  OUT_W  normalised result
out_err  out  1  length mismatch flag, qualified by out_valid
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE, ones=0, nbits=0, len_q=0, out_valid=0, out_value=0, out_err=0, busy=0. Reset mid-stream or mid-hold discards everything.
- Accept = in_valid & in_ready.
- in_ready = 1 in IDLE and ACCUM, 0 in HOLD.
- States:
  - IDLE: on accept, latch len_q=len_log2, ones=in_bit, nbits=1. If the bit terminates (see below), go to HOLD; else go to ACCUM.
  - ACCUM: on accept, ones += in_bit, nbits += 1. If the bit terminates, go to HOLD.
  - HOLD: out_valid=1. out_value and out_err are stable until out_valid & out_ready. On that transfer, go to IDLE next cycle with counters cleared.
- Termination: the accepted bit is the k-th bit (k = nbits after increment) and either in_last=1 or k == 2^len_q. Stream ends at the earlier of the two.
- out_err = 1 if in_last=1 and k != 2^len_q, or if k == 2^len_q and in_last=0. Otherwise out_err = 0.
- Latency: terminating bit accepted at edge t -> out_valid=1, out_value valid after edge t (registered). in_ready=0 from the same point.
- Widths:
  - ones and nbits are CNT_W+1 bits; all-ones at max length = 2^CNT_W with no overflow.
  - len_log2 > CNT_W is clamped to CNT_W.
- Normalisation (always uses declared len_q, including on error):
  - len_q <= OUT_W: v = ones << (OUT_W-len_q).
  - len_q > OUT_W: v = ones >> (len_q-OUT_W), truncating.
  - If v >= 2^OUT_W, out_value = 2^OUT_W-1 (saturate). Otherwise out_value = v[OUT_W-1:0].
- len_q=0: single-bit stream. Go IDLE->HOLD on the first accept. out_value = 2^OUT_W-1 if the bit is 1, else 0.
- flush: has priority over every other event in every state. Next state is IDLE with counters cleared and out_valid=0. Any accept in the flush cycle is dropped. In HOLD, flush with out_ready=1 drops the result; the consumer must ignore that transfer.
- out_valid & out_ready in HOLD and in_valid in the same cycle: the input is not accepted (in_ready=0). The first bit of the next stream is accepted no earlier than the following cycle.

Decomposition:
- Package cape_dec_pkg: state enum (IDLE, ACCUM, HOLD); localparam LEN_W=$clog2(CNT_W+1); normalise/saturate function.
- Sub-module sc_norm_shift: combinational normaliser (ones, len_q -> out_value), unit-testable on its own. FSM and counters live in the top.

Test Plan:
1. len_log2=4, 16 bits 1011_0110_1100_1001 (9 ones), in_last on bit 16 -> out_value=144, out_err=0. out_valid rises the cycle after bit 16.
2. len_log2=3, 8 ones, in_last on bit 8 -> raw 256, saturates to out_value=255, out_err=0.
3. len_log2=12, 4096 bits with 2048 ones, in_last=0 throughout -> terminates on bit 4096, out_value=128, out_err=1.
4. len_log2=3, in_last on bit 5, bits 11010 (3 ones) -> out_value=96, out_err=1. in_ready=0 the next cycle.
5. Backpressure: scenario 1 with out_ready held low 3 cycles -> out_valid stays 1, out_value=144 stable, in_ready=0. Transfer on cycle 4, then IDLE and in_ready=1.
6. Control events:
   - flush after bit 7 -> busy=0 next cycle, no out_valid. The next stream (len=0, bit 1) yields 255.
   - rst_n low mid-ACCUM -> all outputs 0 immediately.
